// File: rtl/vga_pkg.sv
// Shared timing defaults and packed types for the VGA raster path.
package vga_pkg;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;
  localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic active;
  } vga_ctl_t;

  // Idle control word: syncs deasserted, blanked.
  localparam vga_ctl_t CTL_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, active: 1'b0};

endpackage

// File: rtl/vga_raster_controller_if.sv
// VGA connector pin bundle; master drives the DAC pins, slave observes them.
interface vga_raster_controller_if;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;
  logic       clk;
  logic       hs_n;
  logic       vs_n;
  logic       blank_n;
  logic       sync_n;

  modport master (output r, g, b, clk, hs_n, vs_n, blank_n, sync_n);
  modport slave  (input  r, g, b, clk, hs_n, vs_n, blank_n, sync_n);
endinterface

// File: rtl/vga_ctl_delay.sv
// Shift register that delays sync/active by DEPTH pixel ticks to match colour latency.
module vga_ctl_delay
  import vga_pkg::*;
#(
  parameter int DEPTH = 0
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     en_i,
  input  vga_ctl_t ctl_i,
  output vga_ctl_t ctl_o
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_ok;
      assign unused_ok = &{1'b0, clk_i, rst_i, en_i};
      assign ctl_o     = ctl_i;
    end else begin : g_shift
      vga_ctl_t stage_q [DEPTH];

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= CTL_IDLE;
        end else if (en_i) begin
          stage_q[0] <= ctl_i;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign ctl_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_raster_controller.sv
// Raster timing generator: scan position out, colour back in, registered VGA DAC pins.
module vga_raster_controller
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter int RGB_LAT   = 0
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic       pixel_ce,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_start,
  input  logic [7:0] Red,
  input  logic [7:0] Green,
  input  logic [7:0] Blue,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N
);

  localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_VISIBLE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int CE_W     = $clog2(CLK_DIV);

  logic [CE_W-1:0] ce_cnt_q, ce_cnt_d;
  logic [9:0]      hc_q, hc_d;
  logic [9:0]      vc_q, vc_d;
  logic            vga_clk_q, vga_clk_d;
  logic            frame_start_q, frame_start_d;
  vga_ctl_t        ctl_raw, ctl_dly;
  vga_ctl_t        ctl_out_q, ctl_out_d;
  rgb_t            rgb_q, rgb_d;

  assign pixel_ce = (ce_cnt_q == CE_W'(CLK_DIV - 1));

  always_comb begin
    ctl_raw        = CTL_IDLE;
    ctl_raw.active = (hc_q < 10'(H_VISIBLE)) && (vc_q < 10'(V_VISIBLE));
    ctl_raw.hs_n   = !((hc_q >= 10'(HS_START)) && (hc_q < 10'(HS_END)));
    ctl_raw.vs_n   = !((vc_q >= 10'(VS_START)) && (vc_q < 10'(VS_END)));
  end

  vga_ctl_delay #(.DEPTH(RGB_LAT)) u_ctl_delay (
    .clk_i (Clk),
    .rst_i (Reset),
    .en_i  (pixel_ce),
    .ctl_i (ctl_raw),
    .ctl_o (ctl_dly)
  );

  always_comb begin
    ce_cnt_d      = pixel_ce ? '0 : ce_cnt_q + 1'b1;
    hc_d          = hc_q;
    vc_d          = vc_q;
    vga_clk_d     = vga_clk_q;
    ctl_out_d     = ctl_out_q;
    rgb_d         = rgb_q;
    frame_start_d = pixel_ce && (hc_q == 10'(H_TOTAL - 1)) && (vc_q == 10'(V_VISIBLE - 1));

    // DAC clock falls with the pin update and rises mid-pixel.
    if (pixel_ce)                                vga_clk_d = 1'b0;
    else if (ce_cnt_q == CE_W'(CLK_DIV / 2 - 1)) vga_clk_d = 1'b1;

    if (pixel_ce) begin
      if (hc_q == 10'(H_TOTAL - 1)) begin
        hc_d = '0;
        vc_d = (vc_q == 10'(V_TOTAL - 1)) ? '0 : vc_q + 1'b1;
      end else begin
        hc_d = hc_q + 1'b1;
      end
      ctl_out_d = ctl_dly;
      rgb_d     = ctl_dly.active ? '{r: Red, g: Green, b: Blue} : '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ce_cnt_q      <= '0;
      hc_q          <= '0;
      vc_q          <= '0;
      vga_clk_q     <= 1'b0;
      frame_start_q <= 1'b0;
      ctl_out_q     <= CTL_IDLE;
      rgb_q         <= '0;
    end else begin
      ce_cnt_q      <= ce_cnt_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      vga_clk_q     <= vga_clk_d;
      frame_start_q <= frame_start_d;
      ctl_out_q     <= ctl_out_d;
      rgb_q         <= rgb_d;
    end
  end

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign frame_start = frame_start_q;
  assign VGA_CLK     = vga_clk_q;
  assign VGA_HS      = ctl_out_q.hs_n;
  assign VGA_VS      = ctl_out_q.vs_n;
  assign VGA_BLANK_N = ctl_out_q.active;
  assign VGA_R       = rgb_q.r;
  assign VGA_G       = rgb_q.g;
  assign VGA_B       = rgb_q.b;
  assign VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_raster_controller.sv
// Bench for vga_raster_controller: two reduced-timing instances (latency 0 and 2) checked each cycle against a position-arithmetic model.
module tb_vga_raster_controller;

  localparam int HV = 16, HF = 4, HS = 6, HB = 6, HT = HV + HF + HS + HB;
  localparam int VV = 12, VF = 2, VS = 2, VB = 3, VT = VV + VF + VS + VB;
  localparam int D0 = 2, LAT0 = 0;
  localparam int D2 = 4, LAT2 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // ---------------- DUT 0: CLK_DIV 2, no colour latency ----------------
  logic       pce0, fs0;
  logic [9:0] x0, y0;
  logic [7:0] red0 = '0, green0 = '0, blue0 = '0;
  vga_raster_controller_if pins0 ();

  vga_raster_controller #(
    .CLK_DIV(D0), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .RGB_LAT(LAT0)
  ) dut0 (
    .Clk(clk), .Reset(rst), .pixel_ce(pce0), .DrawX(x0), .DrawY(y0),
    .frame_start(fs0), .Red(red0), .Green(green0), .Blue(blue0),
    .VGA_R(pins0.r), .VGA_G(pins0.g), .VGA_B(pins0.b), .VGA_CLK(pins0.clk),
    .VGA_HS(pins0.hs_n), .VGA_VS(pins0.vs_n), .VGA_BLANK_N(pins0.blank_n),
    .VGA_SYNC_N(pins0.sync_n)
  );

  // ---------------- DUT 2: CLK_DIV 4, colour latency 2 ----------------
  logic       pce2, fs2;
  logic [9:0] x2, y2;
  logic [7:0] red2 = '0, green2 = '0, blue2 = '0;
  vga_raster_controller_if pins2 ();

  vga_raster_controller #(
    .CLK_DIV(D2), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .RGB_LAT(LAT2)
  ) dut2 (
    .Clk(clk), .Reset(rst), .pixel_ce(pce2), .DrawX(x2), .DrawY(y2),
    .frame_start(fs2), .Red(red2), .Green(green2), .Blue(blue2),
    .VGA_R(pins2.r), .VGA_G(pins2.g), .VGA_B(pins2.b), .VGA_CLK(pins2.clk),
    .VGA_HS(pins2.hs_n), .VGA_VS(pins2.vs_n), .VGA_BLANK_N(pins2.blank_n),
    .VGA_SYNC_N(pins2.sync_n)
  );

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scan position of pixel tick p counted from reset release.
  function automatic int hc_at(input longint p);
    return int'(p % HT);
  endfunction

  function automatic int vc_at(input longint p);
    return int'((p / HT) % VT);
  endfunction

  // {hs_n, vs_n, active} for the position reached after p ticks.
  function automatic logic [2:0] ctl_at(input longint p);
    int h, v;
    h = hc_at(p);
    v = vc_at(p);
    return {!(h >= HV + HF && h < HV + HF + HS),
            !(v >= VV + VF && v < VV + VF + VS),
            (h < HV && v < VV)};
  endfunction

  // t = Clk edges since the last reset edge; col = colour present at the last pixel tick.
  task automatic check_dut(input string tag, input int d, input int lat, input longint t,
                           input logic [23:0] col, input logic pce, input logic [9:0] x,
                           input logic [9:0] y, input logic fs, input logic vclk,
                           input logic hs, input logic vs, input logic bn, input logic sn,
                           input logic [23:0] rgb);
    longint p;
    int m;
    logic [2:0] ctl;
    logic fs_exp;
    p = t / d;
    m = int'(t % d);
    fs_exp = (m == 0) && (p >= 1) && (hc_at(p - 1) == HT - 1) && (vc_at(p - 1) == VV - 1);
    ctl = 3'b110;
    if (p - 1 - lat >= 0) ctl = ctl_at(p - 1 - lat);
    chk({tag, ".pixel_ce"}, 32'(pce), 32'(m == d - 1));
    chk({tag, ".DrawX"}, 32'(x), 32'(hc_at(p)));
    chk({tag, ".DrawY"}, 32'(y), 32'(vc_at(p)));
    chk({tag, ".frame_start"}, 32'(fs), 32'(fs_exp));
    chk({tag, ".VGA_CLK"}, 32'(vclk), 32'(m >= d / 2));
    chk({tag, ".VGA_HS"}, 32'(hs), 32'(ctl[2]));
    chk({tag, ".VGA_VS"}, 32'(vs), 32'(ctl[1]));
    chk({tag, ".VGA_BLANK_N"}, 32'(bn), 32'(ctl[0]));
    chk({tag, ".VGA_SYNC_N"}, 32'(sn), 32'd0);
    chk({tag, ".VGA_RGB"}, 32'(rgb), ctl[0] ? 32'(col) : 32'd0);
  endtask

  // ---------------- stimulus: random colours for DUT 0 ----------------
  initial begin
    forever begin
      @(posedge clk);
      #2;
      red0   = 8'($urandom);
      green0 = 8'($urandom);
      blue0  = 8'($urandom);
    end
  end

  // ---------------- mapper for DUT 2: colour = DrawX two ticks back ----------------
  initial begin
    logic [9:0] hist0, hist1, xs;
    logic ps, rs;
    hist0 = '0;
    hist1 = '0;
    forever begin
      @(negedge clk);
      ps = pce2;
      xs = x2;
      rs = rst;
      @(posedge clk);
      #2;
      if (ps && !rs) begin
        hist1 = hist0;
        hist0 = xs;
      end
      red2   = hist1[7:0];
      green2 = ~hist1[7:0];
      blue2  = 8'($urandom);
    end
  end

  // ---------------- compare process: model vs both DUTs, every cycle ----------------
  initial begin
    longint t0, t2;
    logic [23:0] col0, col2;
    bit sync;
    longint p;
    logic [2:0] ctl;
    t0 = 0; t2 = 0; col0 = '0; col2 = '0; sync = 0;
    forever begin
      @(negedge clk);
      if (sync) begin
        check_dut("d0", D0, LAT0, t0, col0, pce0, x0, y0, fs0, pins0.clk, pins0.hs_n,
                  pins0.vs_n, pins0.blank_n, pins0.sync_n, {pins0.r, pins0.g, pins0.b});
        check_dut("d2", D2, LAT2, t2, col2, pce2, x2, y2, fs2, pins2.clk, pins2.hs_n,
                  pins2.vs_n, pins2.blank_n, pins2.sync_n, {pins2.r, pins2.g, pins2.b});
        // With the mapper in the loop, a visible pin shows its own pixel index.
        p = t2 / D2;
        if (p - 1 - LAT2 >= 0) begin
          ctl = ctl_at(p - 1 - LAT2);
          if (ctl[0]) chk("d2.R_is_index", 32'(pins2.r), 32'(hc_at(p - 1 - LAT2) % 256));
        end
      end
      // Advance the model over the coming rising edge using inputs that edge will see.
      if (rst) begin
        t0 = 0; t2 = 0; sync = 1;
      end else if (sync) begin
        if (t0 % D0 == D0 - 1) col0 = {red0, green0, blue0};
        if (t2 % D2 == D2 - 1) col2 = {red2, green2, blue2};
        t0++; t2++;
      end
    end
  end

  // ---------------- per-frame totals between consecutive frame_start pulses ----------------
  initial begin
    bit arm0, arm2;
    int iv0, hs0c, vs0c, iv2, hs2c, vs2c;
    arm0 = 0; arm2 = 0;
    iv0 = 0; hs0c = 0; vs0c = 0; iv2 = 0; hs2c = 0; vs2c = 0;
    forever begin
      @(negedge clk);
      if (fs0) begin
        if (arm0) begin
          chk("d0.frame_clks", 32'(iv0), 32'd1216);
          chk("d0.hs_low_clks", 32'(hs0c), 32'd228);
          chk("d0.vs_low_clks", 32'(vs0c), 32'd128);
        end
        arm0 = 1; iv0 = 0; hs0c = 0; vs0c = 0;
      end
      if (fs2) begin
        if (arm2) begin
          chk("d2.frame_clks", 32'(iv2), 32'd2432);
          chk("d2.hs_low_clks", 32'(hs2c), 32'd456);
          chk("d2.vs_low_clks", 32'(vs2c), 32'd256);
        end
        arm2 = 1; iv2 = 0; hs2c = 0; vs2c = 0;
      end
      iv0++; iv2++;
      if (!pins0.hs_n) hs0c++;
      if (!pins0.vs_n) vs0c++;
      if (!pins2.hs_n) hs2c++;
      if (!pins2.vs_n) vs2c++;
      if (rst) begin
        arm0 = 0; arm2 = 0;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int waited;
    bit found;

    rst = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;

    // Divider start-up after release.
    @(negedge clk);
    chk("start.pce0_t0", 32'(pce0), 32'd0);
    chk("start.x0_t0", 32'(x0), 32'd0);
    chk("start.hs0_t0", 32'(pins0.hs_n), 32'd1);
    chk("start.bn0_t0", 32'(pins0.blank_n), 32'd0);
    @(negedge clk);
    chk("start.pce0_t1", 32'(pce0), 32'd1);
    chk("start.pce2_t1", 32'(pce2), 32'd0);
    chk("start.r0_t1", 32'(pins0.r), 32'd0);
    @(negedge clk);
    chk("start.x0_t2", 32'(x0), 32'd1);
    @(negedge clk);
    chk("start.pce2_t3", 32'(pce2), 32'd1);
    chk("start.y2_t3", 32'(y2), 32'd0);

    repeat (3 * 2432) @(posedge clk);

    // Reset of random length at a random point.
    repeat ($urandom_range(1, 500)) @(posedge clk);
    #2 rst = 1'b1;
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #2 rst = 1'b0;
    repeat (2 * 2432) @(posedge clk);

    // One-Clk reset in the middle of the visible area.
    found = 0;
    waited = 0;
    while (!found && waited < 3000) begin
      @(negedge clk);
      waited++;
      if (x0 == 10'd10 && y0 == 10'd7) found = 1;
    end
    chk("midreset.reached", 32'(found), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("midreset.x0", 32'(x0), 32'd0);
    chk("midreset.y0", 32'(y0), 32'd0);
    chk("midreset.hs0", 32'(pins0.hs_n), 32'd1);
    chk("midreset.vs0", 32'(pins0.vs_n), 32'd1);
    chk("midreset.bn0", 32'(pins0.blank_n), 32'd0);
    chk("midreset.x2", 32'(x2), 32'd0);
    chk("midreset.fs0", 32'(fs0), 32'd0);

    repeat (3 * 2432) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
